// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode width and the bitwise opcode encoding.
package alu_pkg;

    localparam int OPW = 2;

    typedef enum logic [OPW-1:0] {
        OP_OR   = 2'b00,
        OP_AND  = 2'b01,
        OP_XOR  = 2'b10,
        OP_ANDN = 2'b11
    } op_t;

endpackage

// File: rtl/bitwise_op_core.sv
// Purely combinational bitwise operator: y = a <op> b, no width growth.
module bitwise_op_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        unique case (op)
            OP_OR:   y = a | b;
            OP_AND:  y = a & b;
            OP_XOR:  y = a ^ b;
            OP_ANDN: y = a & ~b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_bcast_pipe.sv
// Registered bitwise op stage with scalar broadcast, accumulator chaining and
// valid/ready handshakes on both sides (single-entry output register).
module logic_bcast_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OPW   = alu_pkg::OPW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_bcast,
    input  logic [OPW-1:0]   in_op,
    input  logic             in_chain,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_ones
);

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("logic_bcast_pipe: WIDTH must be in 1..64");
    end
    if (OPW != alu_pkg::OPW) begin : g_bad_opw
        $error("logic_bcast_pipe: OPW is fixed by alu_pkg and must not be overridden");
    end

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] result;
    logic             accept;
    logic             xfer;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;

    assign op_a = in_chain ? acc : in_a;
    assign op_b = in_bcast ? {WIDTH{in_b[0]}} : in_b;

    bitwise_op_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a  (op_a),
        .b  (op_b),
        .op (op_t'(in_op)),
        .y  (result)
    );

    // Flags are registered alongside the data so they can never disagree with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_zero  <= 1'b1;
            out_ones  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= result;
            out_zero  <= (result == '0);
            out_ones  <= &result;
        end else if (xfer) begin
            out_valid <= 1'b0;
        end
    end

    // An accepted beat takes priority over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (accept) begin
            acc <= result;
        end else if (clr) begin
            acc <= '0;
        end
    end

endmodule

// File: tb/tb_logic_bcast_pipe.sv
// Bench for logic_bcast_pipe: directed cases plus random traffic against a
// queue/truth-table reference model; also small WIDTH=8 and WIDTH=1 instances.
module tb_logic_bcast_pipe;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=16 instance
    logic        in_valid, in_ready, in_bcast, in_chain, clr;
    logic [15:0] in_a, in_b;
    logic [1:0]  in_op;
    logic        out_valid, out_ready, out_zero, out_ones;
    logic [15:0] out_data;

    logic_bcast_pipe #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_bcast(in_bcast), .in_op(in_op), .in_chain(in_chain), .clr(clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_zero(out_zero), .out_ones(out_ones)
    );

    // WIDTH=8 instance
    logic       v8, rdy8, bc8, ch8, clr8, ov8, ordy8, oz8, oo8;
    logic [7:0] a8, b8, od8;
    logic [1:0] op8;

    logic_bcast_pipe #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v8), .in_ready(rdy8), .in_a(a8), .in_b(b8),
        .in_bcast(bc8), .in_op(op8), .in_chain(ch8), .clr(clr8),
        .out_valid(ov8), .out_ready(ordy8), .out_data(od8),
        .out_zero(oz8), .out_ones(oo8)
    );

    // WIDTH=1 instance
    logic       v1, rdy1, bc1, ch1, clr1, ov1, ordy1, oz1, oo1;
    logic [0:0] a1, b1, od1;
    logic [1:0] op1;

    logic_bcast_pipe #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v1), .in_ready(rdy1), .in_a(a1), .in_b(b1),
        .in_bcast(bc1), .in_op(op1), .in_chain(ch1), .clr(clr1),
        .out_valid(ov1), .out_ready(ordy1), .out_data(od1),
        .out_zero(oz1), .out_ones(oo1)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: pending-result queue (depth <= 1) and accumulator.
    logic [15:0] q[$];
    logic [15:0] obs_log[$];
    logic [15:0] m_acc;
    logic [3:0]  tt [4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each result bit looked up in a 4-entry truth table indexed by {a_bit, b_bit}.
    function automatic logic [15:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                           input logic [1:0] op);
        logic [15:0] r;
        logic [3:0]  t;
        r = '0;
        t = tt[op];
        for (int i = 0; i < 16; i++) r[i] = t[{a[i], b[i]}];
        return r;
    endfunction

    task automatic check_outputs();
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_data", 64'(out_data), 64'(q[0]));
            chk("out_zero", 64'(out_zero), 64'(q[0] == 16'h0000));
            chk("out_ones", 64'(out_ones), 64'(q[0] == 16'hFFFF));
        end
    endtask

    // One cycle: drive at the falling edge, predict the rising edge, check at the next falling edge.
    task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic bc, input logic [1:0] op, input logic ch,
                        input logic cl, input logic ordy);
        logic        exp_ready;
        logic [15:0] opa, opb, r;
        in_valid = v; in_a = a; in_b = b; in_bcast = bc; in_op = op;
        in_chain = ch; clr = cl; out_ready = ordy;
        #1;
        exp_ready = (q.size() == 0) || ordy;
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        if (q.size() != 0 && ordy) begin
            obs_log.push_back(out_data);
            void'(q.pop_front());
        end
        if (v && exp_ready) begin
            opa = ch ? m_acc : a;
            opb = bc ? {16{b[0]}} : b;
            r = ref_op(opa, opb, op);
            q.push_back(r);
            m_acc = r;
        end else if (cl) begin
            m_acc = '0;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    localparam logic [1:0] OR_ = 2'b00, AND_ = 2'b01, XOR_ = 2'b10, ANDN_ = 2'b11;

    initial begin
        tt[0] = 4'b1110;  // OR
        tt[1] = 4'b1000;  // AND
        tt[2] = 4'b0110;  // XOR
        tt[3] = 4'b0100;  // A & ~B
        m_acc = '0;

        rst_n = 1'b0;
        in_valid = 0; in_a = 0; in_b = 0; in_bcast = 0; in_op = 0;
        in_chain = 0; clr = 0; out_ready = 0;
        v8 = 0; a8 = 0; b8 = 0; bc8 = 0; op8 = 0; ch8 = 0; clr8 = 0; ordy8 = 1;
        v1 = 0; a1 = 0; b1 = 0; bc1 = 0; op1 = 0; ch1 = 0; clr1 = 0; ordy1 = 1;

        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data",  64'(out_data),  64'd0);
        chk("rst_zero",  64'(out_zero),  64'd1);
        chk("rst_ones",  64'(out_ones),  64'd0);
        rst_n = 1'b1;

        // Broadcast OR
        step(1, 16'h00F0, 16'h0001, 1, OR_, 0, 0, 1);
        chk("bcast_or1", 64'(out_data), 64'hFFFF);
        chk("bcast_or1_ones", 64'(out_ones), 64'd1);
        step(1, 16'h00F0, 16'hFFFE, 1, OR_, 0, 0, 1);
        chk("bcast_or0", 64'(out_data), 64'h00F0);

        // Chaining and clear
        step(1, 16'h0F0F, 16'h0000, 0, XOR_, 0, 0, 1);
        step(1, 16'h0000, 16'h00FF, 0, XOR_, 1, 0, 1);
        chk("chain_xor", 64'(out_data), 64'h0FF0);
        step(0, 16'h0000, 16'h0000, 0, XOR_, 0, 1, 1);
        step(1, 16'hFFFF, 16'h1234, 0, XOR_, 1, 0, 1);
        chk("chain_after_clr", 64'(out_data), 64'h1234);
        step(0, 16'h0000, 16'h0000, 0, OR_, 0, 0, 1);

        // Backpressure: 4 beats, 3 stalled cycles after the first
        obs_log.delete();
        step(1, 16'h1111, 16'h0000, 0, OR_, 0, 0, 1);
        repeat (3) begin
            step(1, 16'h2222, 16'h0000, 0, OR_, 0, 0, 0);
            chk("stall_data", 64'(out_data), 64'h1111);
        end
        step(1, 16'h2222, 16'h0000, 0, OR_, 0, 0, 1);
        step(1, 16'h3333, 16'h0000, 0, OR_, 0, 0, 1);
        step(1, 16'h4444, 16'h0000, 0, OR_, 0, 0, 1);
        step(0, 16'h0000, 16'h0000, 0, OR_, 0, 0, 1);
        chk("bp_count", 64'(obs_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < obs_log.size(); i++)
            chk("bp_order", 64'(obs_log[i]), 64'(16'h1111 * (i + 1)));

        // Continuous streaming
        for (int i = 0; i < 5; i++) begin
            step(1, 16'(16'h0101 << i), 16'h0000, 0, OR_, 0, 0, 1);
            chk("stream_valid", 64'(out_valid), 64'd1);
        end

        // clr coincident with accept: accept wins
        step(1, 16'hABCD, 16'h0000, 0, OR_, 0, 1, 1);
        step(1, 16'h0000, 16'h0000, 0, OR_, 1, 0, 1);
        chk("clr_vs_accept", 64'(out_data), 64'hABCD);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 9) < 7), 16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 3) == 0), 2'($urandom), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) < 6));
        end

        // Asynchronous reset during a stall
        step(1, 16'h5A5A, 16'h0000, 0, OR_, 0, 0, 0);
        step(0, 16'h0000, 16'h0000, 0, OR_, 0, 0, 0);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_data",  64'(out_data),  64'd0);
        chk("async_rst_zero",  64'(out_zero),  64'd1);
        q.delete();
        m_acc = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 16'h0001, 16'h0000, 0, OR_, 1, 0, 1);
        chk("post_rst_beat", 64'(out_data), 64'h0000);
        step(1, 16'h0001, 16'h0000, 0, OR_, 0, 0, 1);
        chk("post_rst_beat2", 64'(out_data), 64'h0001);
        step(0, 16'h0000, 16'h0000, 0, OR_, 0, 0, 1);

        // WIDTH=8 ops
        a8 = 8'hCC; b8 = 8'hAA; v8 = 1; op8 = AND_;
        @(posedge clk); @(negedge clk);
        chk("w8_and", 64'(od8), 64'h88);
        op8 = XOR_;
        @(posedge clk); @(negedge clk);
        chk("w8_xor", 64'(od8), 64'h66);
        op8 = ANDN_;
        @(posedge clk); @(negedge clk);
        chk("w8_andn", 64'(od8), 64'h44);
        chk("w8_andn_zero", 64'(oz8), 64'd0);
        chk("w8_andn_ones", 64'(oo8), 64'd0);
        v8 = 0;

        // WIDTH=1 flags evaluated independently
        a1 = 1'b1; b1 = 1'b0; v1 = 1; op1 = OR_;
        @(posedge clk); @(negedge clk);
        chk("w1_data1", 64'(od1), 64'd1);
        chk("w1_zero1", 64'(oz1), 64'd0);
        chk("w1_ones1", 64'(oo1), 64'd1);
        op1 = AND_;
        @(posedge clk); @(negedge clk);
        chk("w1_data0", 64'(od1), 64'd0);
        chk("w1_zero0", 64'(oz1), 64'd1);
        chk("w1_ones0", 64'(oo1), 64'd0);
        v1 = 0;

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/logic_bcast_pipe.md
Name: logic_bcast_pipe

Overview:
- Parametrised, registered successor to the 16-bit word-OR-scalar gate.
- Applies one of four bitwise ops (OR, AND, XOR, ANDN) between a WIDTH-bit operand A and either a vector operand B or a scalar broadcast to all bits.
- Optional chaining feeds the previous result back as operand A.
- Sits between the decode/operand stage and writeback of the ALU datapath, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, data width in bits; legal range 1..64.
- OPW, 2, opcode width; fixed by the shared package; not to be overridden.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  unit can accept a beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B vector; only bit 0 is used when in_bcast=1.
- in_bcast  in  1  1 = replicate in_b[0] across all WIDTH bits.
- in_op  in  OPW  00 OR, 01 AND, 10 XOR, 11 ANDN (A & ~B).
- in_chain  in  1  1 = use the accumulator in place of in_a.
- clr  in  1  synchronous clear of the accumulator.
- out_valid  out  1  result held in the output register.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  registered result.
- out_zero  out  1  out_data == 0.
- out_ones  out  1  out_data is all ones.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_zero=1, out_ones=0, acc=0.
  - Reset takes effect mid-transfer; any in-flight result is dropped.
  - Deassertion is synchronous to clk; the first accept can occur on the first edge after release.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - An input is accepted on an edge where in_valid & in_ready.
  - Output transfer occurs on an edge where out_valid & out_ready.
- Latency and throughput: one cycle from accept to out_valid. Back-to-back accepts at one beat per cycle while out_ready=1.
- Output register update:
  - On accept: out_data <= f(opA, opB); out_valid <= 1.
  - Transfer without accept: out_valid <= 0; out_data holds its value.
  - Transfer and accept on the same edge: the new result replaces the old one; out_valid stays 1.
  - Stall (out_valid=1, out_ready=0): out_data, out_valid and the flags are stable. in_ready=0. in_* is ignored.
- Operand selection:
  - opA = in_chain ? acc : in_a.
  - opB = in_bcast ? {WIDTH{in_b[0]}} : in_b.
- Flags: out_zero and out_ones are registered with out_data and are consistent with it in every cycle. When WIDTH=1 and out_data=1, both are evaluated independently (out_zero=0, out_ones=1).
- Accumulator update (acc, WIDTH bits):
  - On accept: acc <= result.
  - clr=1 without accept: acc <= 0.
  - clr and accept on the same edge: accept wins (acc <= result).
  - A chained beat uses the acc value from before that edge.
  - clr has no effect on the output register.
- No arithmetic, carries or sign handling: purely bitwise, with no width growth.
- Illegal parameters (WIDTH < 1 or WIDTH > 64): elaboration-time error.

Decomposition:
- Shared package (alu_pkg) holds:
  - the op encoding constants OP_OR=2'b00, OP_AND=2'b01, OP_XOR=2'b10, OP_ANDN=2'b11;
  - the OPW constant;
  - the op typedef.
- One natural combinational sub-module, bitwise_op_core. Its parameter is WIDTH; its inputs are a, b and op; its output is y. The top instantiates it once and owns the operand muxes, accumulator, output register and handshake.

Test Plan:
- Reset: hold rst_n low mid-stall with out_valid=1 -> out_valid=0, out_data=0, out_zero=1 asynchronously; the first beat after release is accepted normally.
- Broadcast OR at WIDTH=16: A=16'h00F0, in_b=16'h0001, bcast=1, op=OR -> next cycle out_data=16'hFFFF, out_ones=1. Repeat with in_b[0]=0 -> out_data=16'h00F0.
- Ops at WIDTH=8: A=8'hCC, B=8'hAA, bcast=0:
  - op=AND -> out_data=8'h88.
  - op=XOR -> out_data=8'h66.
  - op=ANDN -> out_data=8'h44, with both flags 0.
- Chaining and clear, op=XOR at WIDTH=16:
  - Beats A=16'h0F0F, then chain with B=16'h00FF -> second result 16'h0FF0.
  - Then clr for one cycle, then chain with B=16'h1234 -> result 16'h1234.
- Backpressure: stream 4 beats with out_ready low for 3 cycles after the first -> in_ready=0 during the stall, out_data is stable, no beat is lost or duplicated, and all 4 results appear in order.
- Simultaneous events: out_ready=1 and in_valid=1 on every cycle -> one result per cycle, out_valid continuously 1. clr with accept on the same edge -> acc equals the new result.
